// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared arbiter state encoding and default fetch starvation limit
package mem_port_arbiter_pkg;
  localparam int DEF_MAX_WAIT = 3;
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_ACC_IF = 3'd1,
    ARB_ACC_D  = 3'd2,
    ARB_RSP_IF = 3'd3,
    ARB_RSP_D  = 3'd4
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and memory bus bundle
//   slave modport : arbiter view (requests and mem_rdata in; ready/rdata, mem_* and hold out)
//   master modport: pipeline + memory view (the reverse directions)
interface mem_port_arbiter_if #(parameter int AW = 16);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [15:0]   if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [15:0]   d_wdata;
  logic [15:0]   d_rdata;
  logic          d_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [15:0]   mem_rdata;
  logic          hold;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_wdata, mem_re, mem_we, hold
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_wdata, mem_re, mem_we, hold
  );
endinterface

// File: rtl/mem_port_arbiter_starve.sv
// arb_starve_counter: counts fetch denials and forces a fetch grant once MAX_WAIT is reached
//   clk, pc_reset (async, active-high); inc: data granted over a pending fetch;
//   clr: fetch granted; force_if: fetch must win the next IDLE arbitration
module arb_starve_counter import mem_port_arbiter_pkg::*; #(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic pc_reset,
  input  logic inc,
  input  logic clr,
  output logic force_if
);
  logic [3:0] wait_cnt;
  always_ff @(posedge clk or posedge pc_reset)
    if (pc_reset) wait_cnt <= '0;
    else if (clr) wait_cnt <= '0;
    else if (inc && wait_cnt < 4'(MAX_WAIT)) wait_cnt <= wait_cnt + 4'd1;
  assign force_if = wait_cnt >= 4'(MAX_WAIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read memory between fetch and data ports, data-first with fetch starvation guard
//   clk, pc_reset (async, active-high); bus: fetch/data request ports, memory bus and hold
//   MEM_ARB_PERF_EN adds conflict_cnt (IDLE cycles with both requests) and starve_cnt (forced fetch grants)
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int AW       = 16
) (
  input  logic clk,
  input  logic pc_reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0] conflict_cnt,
  output logic [15:0] starve_cnt
`endif
);
  arb_state_t    state, nxt;
  logic          gnt_if, gnt_d, force_if, idle;
  logic [AW-1:0] l_addr;
  logic [15:0]   l_wdata;
  logic          l_we;
  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (clk),
    .pc_reset(pc_reset),
    .inc     (gnt_d & bus.if_req & idle),
    .clr     (gnt_if),
    .force_if(force_if)
  );
  always_ff @(posedge clk or posedge pc_reset)
    if (pc_reset) state <= ARB_IDLE;
    else state <= nxt;
  // In RSP_x only the other port is arbitrated; the served port still holds req this cycle.
  always_comb begin
    idle   = state == ARB_IDLE;
    gnt_d  = idle ? bus.d_req & (~force_if | ~bus.if_req) : (state == ARB_RSP_IF) & bus.d_req;
    gnt_if = idle ? bus.if_req & ~gnt_d : (state == ARB_RSP_D) & bus.if_req;
    nxt    = gnt_d ? ARB_ACC_D : gnt_if ? ARB_ACC_IF :
             state == ARB_ACC_IF ? ARB_RSP_IF : state == ARB_ACC_D ? ARB_RSP_D : ARB_IDLE;
  end
  always_ff @(posedge clk or posedge pc_reset)
    if (pc_reset) begin
      l_addr  <= '0;
      l_wdata <= '0;
      l_we    <= 1'b0;
    end else if (gnt_d) begin
      l_addr  <= bus.d_addr;
      l_wdata <= bus.d_wdata;
      l_we    <= bus.d_we;
    end else if (gnt_if) begin
      l_addr  <= bus.if_addr;
      l_we    <= 1'b0;
    end
  // mem_we decodes straight from state so it falls with the asynchronous reset.
  always_comb begin
    bus.mem_addr  = l_addr;
    bus.mem_wdata = l_wdata;
    bus.mem_re    = (state == ARB_ACC_IF) | ((state == ARB_ACC_D) & ~l_we);
    bus.mem_we    = (state == ARB_ACC_D) & l_we;
    bus.if_ready  = state == ARB_RSP_IF;
    bus.d_ready   = state == ARB_RSP_D;
    bus.if_rdata  = state == ARB_RSP_IF ? bus.mem_rdata : 16'h0;
    bus.d_rdata   = state == ARB_RSP_D ? bus.mem_rdata : 16'h0;
    bus.hold      = (bus.if_req & (state != ARB_RSP_IF)) | (bus.d_req & (state != ARB_RSP_D));
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge pc_reset)
    if (pc_reset) begin
      conflict_cnt <= '0;
      starve_cnt   <= '0;
    end else begin
      conflict_cnt <= conflict_cnt + 16'(idle & bus.if_req & bus.d_req);
      starve_cnt   <= starve_cnt + 16'(idle & gnt_if & force_if & bus.d_req);
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a sync-read memory model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  typedef struct packed {logic chk; logic [15:0] data;} exp_t;
  logic clk, pc_reset;
  int total = 0, bad = 0;
  exp_t q_if[$], q_d[$];
  exp_t e_if, e_d;
  logic [15:0] mem [int];
  mem_port_arbiter_if #(.AW(16)) bus ();
`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt, starve_cnt;
`endif
  mem_port_arbiter dut (
    .clk     (clk),
    .pc_reset(pc_reset),
    .bus     (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .conflict_cnt(conflict_cnt),
    .starve_cnt  (starve_cnt)
`endif
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a == 16'h0010 ? 16'h1234 : a == 16'h0002 ? 16'h5678 : a == 16'h8000 ? 16'hA5A5 : a;
  endfunction
  always @(posedge clk) begin
    if (bus.mem_we) mem[int'(bus.mem_addr)] = bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : init_val(bus.mem_addr);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (!pc_reset) begin
    if (bus.if_ready && bus.d_ready) begin
      total++;
      bad++;
      $display("FAIL both_ready got=11 exp=one");
    end
    if (bus.if_ready) begin
      total++;
      if (q_if.size() == 0) begin
        bad++;
        $display("FAIL if_unexpected got=ready exp=none");
      end else begin
        e_if = q_if.pop_front();
        if (bus.if_rdata !== e_if.data) begin
          bad++;
          $display("FAIL if_rdata got=%h exp=%h", bus.if_rdata, e_if.data);
        end
      end
    end
    if (bus.d_ready) begin
      total++;
      if (q_d.size() == 0) begin
        bad++;
        $display("FAIL d_unexpected got=ready exp=none");
      end else begin
        e_d = q_d.pop_front();
        if (e_d.chk && bus.d_rdata !== e_d.data) begin
          bad++;
          $display("FAIL d_rdata got=%h exp=%h", bus.d_rdata, e_d.data);
        end
      end
    end
  end
  initial begin
    pc_reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_re", {31'b0, bus.mem_re}, 0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 0);
    chk("rst_ready", {30'b0, bus.if_ready, bus.d_ready}, 0);
    chk("rst_mem_addr", {16'b0, bus.mem_addr}, 0);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    chk("rst_hold", {31'b0, bus.hold}, 0);
    chk("rst_wait", {28'b0, dut.u_starve.wait_cnt}, 0);
    tick; pc_reset = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    chk("idle_no_access", {30'b0, bus.mem_re, bus.mem_we}, 0);
    // write then read back
    tick; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hBEEF; q_d.push_back('{1'b0, 16'h0});
    @(negedge clk); chk("wr_c0_we", {31'b0, bus.mem_we}, 0); chk("wr_c0_hold", {31'b0, bus.hold}, 1);
    tick; @(negedge clk);
    chk("wr_c1_we", {30'b0, bus.mem_we, bus.mem_re}, 2);
    chk("wr_c1_addr", {bus.mem_wdata, bus.mem_addr}, 32'hBEEF_0100);
    tick; @(negedge clk);
    chk("wr_c2_ready", {30'b0, bus.d_ready, bus.mem_we}, 2); chk("wr_c2_hold", {31'b0, bus.hold}, 0);
    tick; bus.d_req = 0; @(negedge clk); chk("wr_c3_ready", {31'b0, bus.d_ready}, 0);
    tick; bus.d_req = 1; bus.d_we = 0; q_d.push_back('{1'b1, 16'hBEEF});
    tick; @(negedge clk); chk("rd_c1_re", {30'b0, bus.mem_re, bus.mem_we}, 2);
    tick; @(negedge clk); chk("rd_c2_ready", {31'b0, bus.d_ready}, 1);
    tick; bus.d_req = 0;
    // lone fetch
    tick; bus.if_req = 1; bus.if_addr = 16'h0010; q_if.push_back('{1'b1, 16'h1234});
    @(negedge clk); chk("lf_c0", {30'b0, bus.hold, bus.mem_re}, 2);
    tick; @(negedge clk);
    chk("lf_c1_re", {30'b0, bus.hold, bus.mem_re}, 3); chk("lf_c1_addr", {16'b0, bus.mem_addr}, 32'h10);
    tick; @(negedge clk); chk("lf_c2", {30'b0, bus.if_ready, bus.hold}, 2);
    tick; bus.if_req = 0;
    // simultaneous requests: data first, fetch straight from RSP_D
    tick; bus.if_req = 1; bus.if_addr = 16'h0002; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h8000;
    q_if.push_back('{1'b1, 16'h5678}); q_d.push_back('{1'b1, 16'hA5A5});
    @(negedge clk); chk("sim_c0", {30'b0, bus.hold, bus.mem_re}, 2);
    tick; @(negedge clk); chk("sim_c1", {15'b0, bus.mem_re, bus.mem_addr}, 32'h1_8000);
    tick; @(negedge clk); chk("sim_c2", {29'b0, bus.d_ready, bus.if_ready, bus.mem_re}, 4);
    tick; bus.d_req = 0; @(negedge clk); chk("sim_c3", {15'b0, bus.mem_re, bus.mem_addr}, 32'h1_0002);
    tick; @(negedge clk); chk("sim_c4", {31'b0, bus.if_ready}, 1);
    tick; bus.if_req = 0;
    // starvation: fetch asserted at three data-granting arbitrations, then forced
    for (int r = 0; r < 3; r++) begin
      tick; bus.if_req = 1; bus.d_req = 1; q_d.push_back('{1'b1, 16'hA5A5});
      tick; bus.if_req = 0; @(negedge clk);
      chk("stv_data_addr", {15'b0, bus.mem_re, bus.mem_addr}, 32'h1_8000);
      chk("stv_wait", {28'b0, dut.u_starve.wait_cnt}, r + 1);
      tick; @(negedge clk); chk("stv_dready", {31'b0, bus.d_ready}, 1);
      tick; bus.d_req = 0;
    end
    tick; bus.if_req = 1; bus.d_req = 1; q_if.push_back('{1'b1, 16'h5678}); q_d.push_back('{1'b1, 16'hA5A5});
    tick; @(negedge clk);
    chk("stv_force_addr", {15'b0, bus.mem_re, bus.mem_addr}, 32'h1_0002);
    chk("stv_wait_clr", {28'b0, dut.u_starve.wait_cnt}, 0);
    tick; @(negedge clk); chk("stv_ifready", {31'b0, bus.if_ready}, 1);
    tick; bus.if_req = 0; @(negedge clk); chk("stv_after", {15'b0, bus.mem_re, bus.mem_addr}, 32'h1_8000);
    tick; @(negedge clk); chk("stv_dready2", {31'b0, bus.d_ready}, 1);
    tick; bus.d_req = 0;
`ifdef MEM_ARB_PERF_EN
    @(negedge clk);
    chk("perf_conflict", {16'b0, conflict_cnt}, 5);
    chk("perf_starve", {16'b0, starve_cnt}, 1);
`endif
    // reset during a write access
    tick; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1111;
    tick; @(negedge clk); chk("rma_we", {31'b0, bus.mem_we}, 1);
    #2 pc_reset = 1; #1;
    chk("rma_we_drop", {30'b0, bus.mem_we, bus.mem_re}, 0);
    chk("rma_state", {29'b0, dut.state}, {29'b0, ARB_IDLE});
    chk("rma_out", {15'b0, bus.d_ready, bus.mem_addr}, 0);
`ifdef MEM_ARB_PERF_EN
    chk("rma_perf", {conflict_cnt, starve_cnt}, 0);
`endif
    bus.d_req = 0; bus.d_we = 0;
    tick; pc_reset = 0; @(negedge clk); chk("rma_no_ready", {31'b0, bus.d_ready}, 0);
    tick; bus.d_req = 1; q_d.push_back('{1'b1, 16'h0200});
    tick; tick; @(negedge clk); chk("rma_rd_ready", {31'b0, bus.d_ready}, 1);
    tick; bus.d_req = 0;
    repeat (3) tick;
    chk("q_if_empty", q_if.size(), 0);
    chk("q_d_empty", q_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
